// File: rtl/pw_multi_pattern_matcher.sv
// ---------------------------------------------------------------------------
// pw_multi_pattern_matcher
//
// Front-end byte-stream pattern matcher. Incoming bytes are shifted into a
// sliding window of pPATTERN_BYTES bytes. Every valid beat, each enabled
// pattern is compared (under its per-bit mask) against the newest Lk bytes of
// the window, so overlapping and restarting occurrences are always found.
// Hits are counted once per beat; once the count reaches the programmed
// target the block enters FIRED and stays there until a release event.
// An inter-byte timeout flushes stale partial matches without losing the
// hit count.
//
// Ports
//   fe_clk            sole clock
//   reset_i           asynchronous, active-high reset
//   I_arm             level, matcher armed while high
//   I_clear           one-cycle pulse, abandon current match/count
//   I_patterns        pattern k at [k*pPATTERN_BYTES*8 +: pPATTERN_BYTES*8],
//                     byte 0 (LSB) is the first byte on the wire
//   I_masks           per-bit compare enable, same layout as I_patterns
//   I_lengths         length of pattern k at [8k +: 8]
//   I_pattern_enable  per-pattern enable
//   I_action          `PM_CAPTURE or `PM_TRIGGER
//   I_match_target    hits required to fire (0 behaves as 1)
//   I_timeout         idle cycles before window flush (0 disables)
//   I_fe_data         front-end data byte
//   I_fe_data_valid   qualifier for I_fe_data
//   I_capturing       capture in progress; falling edge releases FIRED
//   I_trigger_pulse   trigger-done pulse; releases FIRED
//   O_match           high while FIRED
//   O_match_id        lowest-index pattern that hit on the firing beat
//   O_match_capture   O_match qualified by capture action
//   O_match_trigger   one-cycle pulse on entry to FIRED with trigger action
//   O_match_count     hits counted since arm/clear/release
//   O_state           0=IDLE, 1=ARMED, 2=FIRED
//
// Handshake: I_fe_data is consumed on every cycle where I_fe_data_valid is
// high and the matcher is ARMED; there is no back-pressure (no ready).
// ---------------------------------------------------------------------------

`ifndef PM_CAPTURE
`define PM_CAPTURE 2'd1
`endif
`ifndef PM_TRIGGER
`define PM_TRIGGER 2'd2
`endif

module pw_multi_pattern_matcher #(
  parameter int pPATTERN_BYTES = 8,
  parameter int pNUM_PATTERNS  = 4,
  parameter int pCOUNT_WIDTH   = 16
) (
  input  logic                                      fe_clk,
  input  logic                                      reset_i,
  input  logic                                      I_arm,
  input  logic                                      I_clear,
  input  logic [pNUM_PATTERNS*pPATTERN_BYTES*8-1:0] I_patterns,
  input  logic [pNUM_PATTERNS*pPATTERN_BYTES*8-1:0] I_masks,
  input  logic [pNUM_PATTERNS*8-1:0]                I_lengths,
  input  logic [pNUM_PATTERNS-1:0]                  I_pattern_enable,
  input  logic [1:0]                                I_action,
  input  logic [pCOUNT_WIDTH-1:0]                   I_match_target,
  input  logic [pCOUNT_WIDTH-1:0]                   I_timeout,
  input  logic [7:0]                                I_fe_data,
  input  logic                                      I_fe_data_valid,
  input  logic                                      I_capturing,
  input  logic                                      I_trigger_pulse,
  output logic                                      O_match,
  output logic [((pNUM_PATTERNS > 1) ? $clog2(pNUM_PATTERNS) : 1)-1:0] O_match_id,
  output logic                                      O_match_capture,
  output logic                                      O_match_trigger,
  output logic [pCOUNT_WIDTH-1:0]                   O_match_count,
  output logic [1:0]                                O_state
);

  localparam int ID_W   = (pNUM_PATTERNS > 1) ? $clog2(pNUM_PATTERNS) : 1;
  localparam int WIN_W  = pPATTERN_BYTES * 8;
  localparam int FILL_W = $clog2(pPATTERN_BYTES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                  r_state;
  logic [WIN_W-1:0]        r_win;        // newest byte in [7:0]
  logic [FILL_W-1:0]       r_fill;       // valid bytes in window, saturating
  logic [pCOUNT_WIDTH-1:0] r_count;
  logic [pCOUNT_WIDTH-1:0] r_idle;       // cycles since last valid beat
  logic [ID_W-1:0]         r_match_id;
  logic                    r_trig;
  logic                    r_capturing;  // previous I_capturing for edge detect

  // -------------------------------------------------------------------------
  // Window update and timeout
  // -------------------------------------------------------------------------
  logic                    w_timeout_flush;
  logic [FILL_W-1:0]       w_fill_base;
  logic [FILL_W-1:0]       w_fill_after;
  logic [WIN_W-1:0]        w_win_next;

  // A beat arriving on the same cycle the idle count reaches the timeout
  // sees an empty window: the stale bytes are discarded before it is added.
  assign w_timeout_flush = (I_timeout != '0) && (r_idle == I_timeout) &&
                           (r_fill != '0);
  assign w_fill_base     = w_timeout_flush ? '0 : r_fill;
  assign w_fill_after    = (w_fill_base >= FILL_W'(pPATTERN_BYTES)) ?
                           FILL_W'(pPATTERN_BYTES) : w_fill_base + 1'b1;
  assign w_win_next      = (r_win << 8) | WIN_W'(I_fe_data);

  // -------------------------------------------------------------------------
  // Per-pattern compare against the window as it will be after this beat
  // -------------------------------------------------------------------------
  logic [7:0]               w_len [pNUM_PATTERNS];
  logic [pNUM_PATTERNS-1:0] w_hit_vec;
  logic                     w_any_hit;
  logic [ID_W-1:0]          w_first_id;

  always_comb begin
    for (int k = 0; k < pNUM_PATTERNS; k++) begin
      if (I_lengths[8*k +: 8] > 8'(pPATTERN_BYTES))
        w_len[k] = 8'(pPATTERN_BYTES);
      else
        w_len[k] = I_lengths[8*k +: 8];
    end
  end

  // Pattern byte i lines up with the window byte (Lk-1-i) positions behind
  // the newest one, so pattern byte 0 meets the oldest of the last Lk bytes.
  always_comb begin
    w_hit_vec = '0;
    for (int k = 0; k < pNUM_PATTERNS; k++) begin
      w_hit_vec[k] = I_pattern_enable[k] && (w_len[k] != 8'd0) &&
                     (int'(w_fill_after) >= int'(w_len[k]));
      for (int i = 0; i < pPATTERN_BYTES; i++) begin
        for (int j = 0; j < pPATTERN_BYTES; j++) begin
          if ((i < int'(w_len[k])) && (j == int'(w_len[k]) - 1 - i)) begin
            if (((w_win_next[j*8 +: 8] ^
                  I_patterns[(k*pPATTERN_BYTES + i)*8 +: 8]) &
                 I_masks[(k*pPATTERN_BYTES + i)*8 +: 8]) != 8'd0)
              w_hit_vec[k] = 1'b0;
          end
        end
      end
    end
  end

  assign w_any_hit = |w_hit_vec;

  // Lowest index wins when several patterns end on the same byte.
  always_comb begin
    w_first_id = '0;
    for (int k = pNUM_PATTERNS - 1; k >= 0; k--) begin
      if (w_hit_vec[k])
        w_first_id = ID_W'(k);
    end
  end

  // -------------------------------------------------------------------------
  // Counting, target and release
  // -------------------------------------------------------------------------
  logic [pCOUNT_WIDTH-1:0] w_count_inc;
  logic [pCOUNT_WIDTH-1:0] w_target;
  logic                    w_capture_done;
  logic                    w_release;

  assign w_count_inc    = (r_count == '1) ? r_count : r_count + 1'b1;
  assign w_target       = (I_match_target == '0) ?
                          {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1} : I_match_target;
  assign w_capture_done = r_capturing && !I_capturing;
  assign w_release      = I_clear || w_capture_done || I_trigger_pulse;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_win       <= '0;
      r_fill      <= '0;
      r_count     <= '0;
      r_idle      <= '0;
      r_match_id  <= '0;
      r_trig      <= 1'b0;
      r_capturing <= 1'b0;
    end else begin
      r_capturing <= I_capturing;
      r_trig      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_fill  <= '0;
          r_count <= '0;
          r_idle  <= '0;
          if (I_arm)
            r_state <= ST_ARMED;
        end

        ST_ARMED: begin
          if (I_clear) begin
            r_fill  <= '0;
            r_count <= '0;
            r_idle  <= '0;
          end else if (!I_arm) begin
            r_state <= ST_IDLE;
            r_fill  <= '0;
            r_count <= '0;
            r_idle  <= '0;
          end else if (I_fe_data_valid) begin
            r_win  <= w_win_next;
            r_fill <= w_fill_after;
            r_idle <= '0;
            // The window is kept after a hit so overlapping occurrences
            // keep counting toward the target.
            if (w_any_hit) begin
              r_count <= w_count_inc;
              if (w_count_inc >= w_target) begin
                r_state    <= ST_FIRED;
                r_match_id <= w_first_id;
                r_trig     <= (I_action == `PM_TRIGGER);
              end
            end
          end else begin
            if (r_idle != '1)
              r_idle <= r_idle + 1'b1;
            if (w_timeout_flush)
              r_fill <= '0;
          end
        end

        ST_FIRED: begin
          // Bytes are ignored here; dropping I_arm alone does not release.
          r_idle <= '0;
          if (w_release) begin
            r_count <= '0;
            r_fill  <= '0;
            r_state <= I_arm ? ST_ARMED : ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_fill  <= '0;
          r_count <= '0;
          r_idle  <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign O_match         = (r_state == ST_FIRED);
  assign O_match_id      = r_match_id;
  assign O_match_capture = (r_state == ST_FIRED) && (I_action == `PM_CAPTURE);
  assign O_match_trigger = r_trig;
  assign O_match_count   = r_count;
  assign O_state         = r_state;

endmodule

// File: doc/pw_multi_pattern_matcher.md
# pw_multi_pattern_matcher

Next-generation front-end pattern matcher: compares the incoming USB front-end byte stream against up to pNUM_PATTERNS independent, masked, variable-length patterns using a sliding byte window, so overlapping and restarting matches are always found. Counts hits and fires only after a programmable number of matches. Supports an inter-byte timeout that flushes stale partial matches. Sits between the register block and the capture/trigger blocks in the fe_clk domain; all inputs are synchronous to fe_clk.

## Interface
- pPATTERN_BYTES, 8, window depth and maximum pattern length in bytes
- pNUM_PATTERNS, 4, number of independent patterns
- pCOUNT_WIDTH, 16, width of match counter, match target and timeout
- fe_clk  in  1  sole clock
- reset_i  in  1  asynchronous, active-high reset
- I_arm  in  1  level; matcher armed while high
- I_clear  in  1  one-cycle pulse; abandon current match/count
- I_patterns  in  pNUM_PATTERNS*pPATTERN_BYTES*8  pattern k at [k*pPATTERN_BYTES*8 +: pPATTERN_BYTES*8]; byte 0 (LSB) is first byte on the wire
- I_masks  in  same as I_patterns  per-bit compare enable, same layout
- I_lengths  in  pNUM_PATTERNS*8  length of pattern k at [8k +: 8]
- I_pattern_enable  in  pNUM_PATTERNS  per-pattern enable
- I_action  in  2  `PM_CAPTURE or `PM_TRIGGER
- I_match_target  in  pCOUNT_WIDTH  hits required to fire; 0 treated as 1
- I_timeout  in  pCOUNT_WIDTH  max cycles between valid bytes before window flush; 0 disables
- I_fe_data  in  8  front-end data byte
- I_fe_data_valid  in  1  I_fe_data qualifier
- I_capturing  in  1  capture in progress
- I_trigger_pulse  in  1  one-cycle trigger-done pulse
- O_match  out  1  level, high in FIRED
- O_match_id  out  max(1,$clog2(pNUM_PATTERNS))  index of pattern whose hit fired
- O_match_capture  out  1  O_match && I_action==`PM_CAPTURE
- O_match_trigger  out  1  one-cycle pulse on entry to FIRED when I_action==`PM_TRIGGER
- O_match_count  out  pCOUNT_WIDTH  hits counted since arm/clear
- O_state  out  2  0=IDLE, 1=ARMED, 2=FIRED

## Operation
- Window W: pPATTERN_BYTES bytes plus fill counter F (saturates at pPATTERN_BYTES). On each valid beat in ARMED, byte shifts in; F increments. Flush = F<=0 (contents don't care).
- Effective length Lk = min(I_lengths[k], pPATTERN_BYTES). Hit k on a valid beat iff enable[k], Lk≠0, F_after≥Lk, and for every i<Lk: (byte received i positions before the newest counting from oldest of last Lk) & mask_k[i] == pattern_k[i] & mask_k[i]; i.e. last Lk bytes, oldest first, equal pattern bytes 0..Lk-1 under mask.
- Any hit on a beat: O_match_count += 1 (once per beat regardless of how many patterns hit; saturating). Firing id = lowest-index hitting pattern.
- Window is not flushed after a non-firing hit: overlapping occurrences count.
- States: IDLE: window flushed, count 0; -> ARMED when I_arm. ARMED: -> FIRED when a hit makes count ≥ effective target; O_match_id latched. -> IDLE when I_arm low. FIRED: holds; released by capture_done (I_capturing falling edge, registered compare), I_trigger_pulse, or I_clear; on release count 0, window flushed, -> ARMED if I_arm else IDLE. Bytes arriving in FIRED are ignored.
- I_clear in ARMED: count 0, window flushed, stay ARMED. Priority: I_clear > release > I_arm low > hit.
- Timeout: idle counter in ARMED resets on each valid beat, increments otherwise (saturating); when it equals I_timeout (≠0) with F>0, window flushed; count kept.
- I_arm falling in FIRED does not release; release event required.

## Timing
- Reset: state IDLE, all outputs 0, F=0, counters 0.
- Hit latency: valid beat at cycle n -> O_match_count updated, O_match/O_state/O_match_id at n+1; O_match_trigger high only cycle n+1.
- Release event at cycle n -> O_match low at n+1; a valid beat at n+1 is matchable (window empty).
- I_arm high at cycle n -> ARMED at n+1; beat at n is not captured.
- Register inputs (patterns, masks, lengths, target, action) must be static while ARMED/FIRED; changes take effect next beat.

## Test plan
- Single pattern 0xA5 0x5A (L=2, mask FF), stream 00 A5 5A -> O_match 1 cycle after 5A, id 0, O_match_trigger one pulse with `PM_TRIGGER.
- Restart: pattern 01 01 02, stream 01 01 01 02 -> fires on 02 (partial-restart case).
- Overlap + target=2: pattern AA AA, stream AA AA AA -> count 1 then 2, fires on third byte.
- Simultaneous: patterns 0 and 2 both end on same byte -> count +1 only, O_match_id=0.
- Timeout=3: pattern 11 22, send 11, idle 3 cycles, 22 -> no hit; idle 2 cycles -> hit.
- Release/reset: in FIRED pulse I_trigger_pulse with I_arm high -> ARMED, count 0; assert reset_i mid-pattern -> all outputs 0 immediately, IDLE.
